writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Writeback stage plus architectural integer register file for the 5-stage RV32I pipeline. It consumes the memory/writeback pipeline register outputs, selects the writeback value, and commits it to x1–x31. It serves two combinational read ports to decode, drives a writeback forwarding bus to execute, and emits a registered retire record plus a retired-instruction counter.

## Interface
Parameters:
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  reset, asynchronous and active-low.
- i_pc  in  32  PC of the instruction in writeback.
- i_instr  in  32  instruction word; rd = i_instr[11:7].
- i_insn_vld  in  1  writeback slot holds a real instruction, not a bubble.
- i_rd_wren  in  1  instruction writes rd.
- i_ld_data  in  32  load data, already aligned and sign/zero-extended.
- i_wb_sel  in  2  writeback source select.
- i_alu_data  in  32  ALU result.
- i_rs1_addr, i_rs2_addr  in  5  decode read addresses.
- o_rs1_data, o_rs2_data  out  32  read data; combinational.
- o_wb_we  out  1  commit strobe this cycle; combinational.
- o_wb_rd  out  5  commit destination; combinational.
- o_wb_data  out  32  selected writeback value; combinational, used as the EX forwarding source.
- o_retire_vld  out  1  registered retire strobe.
- o_retire_pc, o_retire_data  out  32  registered retire PC and writeback value.
- o_retire_rd  out  5  registered retire destination; 0 when nothing was written.
- o_instret  out  INSTRET_W  count of retired instructions.

## Operation
- Writeback select: i_wb_sel 2'b00 → i_pc+4; 2'b01 → i_alu_data; 2'b10 → i_ld_data; 2'b11 → i_alu_data (reserved).
- PC+4 addition is modulo 2^32.
- Commit condition: o_wb_we = i_insn_vld & i_rd_wren & (rd != 0). When o_wb_we is high, regs[rd] is written with o_wb_data at the clock edge.
- x0 reads return 0 always. Writes to x0 are dropped: o_wb_we = 0 and o_wb_rd = 0.
- When o_wb_we = 0, o_wb_rd = 0. o_wb_data is always driven with the mux result.
- Read ports: o_rsN_data = regs[i_rsN_addr], with the bypass behaviour defined in Configuration.
- Retire record, registered every cycle:
  - o_retire_vld ← i_insn_vld.
  - o_retire_pc ← i_pc.
  - o_retire_data ← o_wb_data.
  - o_retire_rd ← o_wb_rd.
- Counter: o_instret increments by 1 on each cycle with i_insn_vld = 1, whether or not the instruction writes rd. It wraps from all-ones to 0 silently.
- There is no stall input. The upstream pipeline register holds its outputs when stalled; the upstream holds i_insn_vld = 0 when a held instruction must not re-commit.

## Timing
- Reset (asynchronous assert; deassert synchronised by the top level):
  - regs[1..31] = 0, o_retire_vld = 0, o_retire_pc = 0, o_retire_data = 0, o_retire_rd = 0, o_instret = 0.
  - Combinational outputs follow the inputs during reset, but no state changes while i_rst_n = 0.
- Register write latency: 1 edge. Without bypass, a read of the same register sees new data in the cycle after the commit edge.
- Retire outputs lag the writeback slot by exactly 1 cycle.
- Reset asserted mid-operation: an in-flight commit in that cycle is lost; all state clears immediately.
- Simultaneous rs1 = rs2 = rd: both read ports obey the same bypass rule.

## Configuration
- WB_BYPASS_EN defined: write-through. If o_wb_we = 1 and i_rsN_addr == o_wb_rd, then o_rsN_data = o_wb_data in the same cycle. This removes the WB→ID hazard.
- WB_BYPASS_EN undefined: reads return stored register contents only. The hazard unit must then stall decode for one cycle on a WB→ID dependency.
- Neither setting changes o_wb_*, the retire outputs, or o_instret.

## Structure
- Shared package rv_pipe_pkg contains:
  - wb_sel_e enum: WB_PC4 = 2'b00, WB_ALU = 2'b01, WB_LD = 2'b10, WB_RSVD = 2'b11.
  - Constant NOP_INSTR = 32'h00000013.
  - Field-position constants RD_LSB = 7, RD_MSB = 11.
- Sub-module rv_regfile holds storage, the x0 rule, and the optional bypass: one write port, two read ports, async reset. The writeback mux, commit logic, retire register and counter stay in writeback_regfile.

## Test plan
- Reset → o_instret = 0, o_retire_vld = 0. Reads of x1..x31 all return 0.
- Commit ALU result: vld = 1, wren = 1, rd = 5, sel = 01, alu = 32'hDEADBEEF → next cycle reading x5 returns DEADBEEF. Retire record is {1, pc, 5, DEADBEEF}.
- Write to x0: rd = 0, alu = 32'h1234 → o_wb_we = 0; x0 still reads 0; o_retire_rd = 0; o_instret still increments.
- Bubble: vld = 0, wren = 1, rd = 7 → x7 unchanged and o_instret unchanged.
- Same-cycle read of the register being written: rs1 = rs2 = rd = 3, sel = 10, ld = 32'h55 → with WB_BYPASS_EN both ports read 55 that cycle; without it both read the old value, then 55 next cycle.
- JAL link: sel = 00, pc = 32'hFFFFFFFC → write data 0 (PC+4 wraps). Separately, preload o_instret to all-ones via force and retire once → o_instret = 0.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: writeback source select, NOP encoding and
// the rd field position inside the instruction word.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    WB_PC4  = 2'b00,
    WB_ALU  = 2'b01,
    WB_LD   = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;

endpackage

// File: rtl/rv_regfile.sv
// Architectural integer register file: one write port, two combinational read ports.
// Optional write-through bypass from the write port when WB_BYPASS_EN is defined.
module rv_regfile
  import rv_pipe_pkg::*;
#(
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [31:0]   o_rdata1,
  output logic [31:0]   o_rdata2
);

  logic [31:0] regs [NREG];

  // Entry 0 is never written; it exists only to keep the index range simple.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1 = (i_raddr1 == '0) ? 32'h0 : regs[i_raddr1];
    o_rdata2 = (i_raddr2 == '0) ? 32'h0 : regs[i_raddr2];
`ifdef WB_BYPASS_EN
    if (i_we && (i_waddr != '0) && (i_raddr1 == i_waddr)) o_rdata1 = i_wdata;
    if (i_we && (i_waddr != '0) && (i_raddr2 == i_waddr)) o_rdata2 = i_wdata;
`endif
  end

endmodule

// File: rtl/writeback_regfile.sv
// RV32I writeback stage: source mux, commit to the register file, retire record and
// instret counter. Define WB_BYPASS_EN for same-cycle write-through on the read ports.
module writeback_regfile
  import rv_pipe_pkg::*;
#(
  parameter int NREG      = 32,
  parameter int INSTRET_W = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_pc,
  input  logic [31:0]          i_instr,
  input  logic                 i_insn_vld,
  input  logic                 i_rd_wren,
  input  logic [31:0]          i_ld_data,
  input  logic [1:0]           i_wb_sel,
  input  logic [31:0]          i_alu_data,
  input  logic [4:0]           i_rs1_addr,
  input  logic [4:0]           i_rs2_addr,
  output logic [31:0]          o_rs1_data,
  output logic [31:0]          o_rs2_data,
  output logic                 o_wb_we,
  output logic [4:0]           o_wb_rd,
  output logic [31:0]          o_wb_data,
  output logic                 o_retire_vld,
  output logic [31:0]          o_retire_pc,
  output logic [31:0]          o_retire_data,
  output logic [4:0]           o_retire_rd,
  output logic [INSTRET_W-1:0] o_instret
);

  logic [4:0]           rd;
  logic                 unused_instr;
  logic [INSTRET_W-1:0] instret_q;

  assign rd           = i_instr[RD_MSB:RD_LSB];
  assign unused_instr = ^{i_instr[31:RD_MSB+1], i_instr[RD_LSB-1:0]};

  always_comb begin
    o_wb_data = i_alu_data;
    case (wb_sel_e'(i_wb_sel))
      WB_PC4:  o_wb_data = i_pc + 32'd4;
      WB_ALU:  o_wb_data = i_alu_data;
      WB_LD:   o_wb_data = i_ld_data;
      default: o_wb_data = i_alu_data;
    endcase
  end

  // Writes to x0 are suppressed here so o_wb_rd doubles as a "nothing written" marker.
  assign o_wb_we = i_insn_vld & i_rd_wren & (rd != 5'd0);
  assign o_wb_rd = o_wb_we ? rd : 5'd0;

  rv_regfile #(.NREG(NREG)) u_regfile (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_we     (o_wb_we),
    .i_waddr  (o_wb_rd),
    .i_wdata  (o_wb_data),
    .i_raddr1 (i_rs1_addr),
    .i_raddr2 (i_rs2_addr),
    .o_rdata1 (o_rs1_data),
    .o_rdata2 (o_rs2_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_retire_vld  <= 1'b0;
      o_retire_pc   <= '0;
      o_retire_data <= '0;
      o_retire_rd   <= '0;
      instret_q     <= '0;
    end else begin
      o_retire_vld  <= i_insn_vld;
      o_retire_pc   <= i_pc;
      o_retire_data <= o_wb_data;
      o_retire_rd   <= o_wb_rd;
      if (i_insn_vld) instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign o_instret = instret_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Self-checking bench for writeback_regfile; retire records are scoreboarded
// when each slot is driven and compared one edge later.
module tb_writeback_regfile;
  import rv_pipe_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_instr = '0;
  logic        i_insn_vld = 1'b0;
  logic        i_rd_wren = 1'b0;
  logic [31:0] i_ld_data = '0;
  logic [1:0]  i_wb_sel = '0;
  logic [31:0] i_alu_data = '0;
  logic [4:0]  i_rs1_addr = '0;
  logic [4:0]  i_rs2_addr = '0;
  logic [31:0] o_rs1_data, o_rs2_data, o_wb_data;
  logic        o_wb_we, o_retire_vld;
  logic [4:0]  o_wb_rd, o_retire_rd;
  logic [31:0] o_retire_pc, o_retire_data;
  logic [63:0] o_instret;

  writeback_regfile dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .i_instr(i_instr),
    .i_insn_vld(i_insn_vld), .i_rd_wren(i_rd_wren), .i_ld_data(i_ld_data),
    .i_wb_sel(i_wb_sel), .i_alu_data(i_alu_data), .i_rs1_addr(i_rs1_addr),
    .i_rs2_addr(i_rs2_addr), .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .o_wb_we(o_wb_we), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
    .o_retire_vld(o_retire_vld), .o_retire_pc(o_retire_pc),
    .o_retire_data(o_retire_data), .o_retire_rd(o_retire_rd), .o_instret(o_instret)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
  } ret_t;

  ret_t        sb[$];
  logic [31:0] mregs [32];
  logic [63:0] minstret;
  logic        pend_we, pend_vld;
  logic [4:0]  pend_rd;
  logic [31:0] pend_data;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic [31:0] model_wb(logic [1:0] sel, logic [31:0] pc,
                                           logic [31:0] alu, logic [31:0] ld);
    case (sel)
      2'b00:   return pc + 32'd4;
      2'b10:   return ld;
      default: return alu;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (pend_we && a == pend_rd) return pend_data;
`endif
    return mregs[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    minstret = '0;
    pend_we = 1'b0; pend_vld = 1'b0; pend_rd = '0; pend_data = '0;
    sb.delete();
  endtask

  task automatic drive(input logic vld, input logic wren, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] ld);
    ret_t r;
    i_insn_vld = vld; i_rd_wren = wren; i_wb_sel = sel; i_pc = pc;
    i_alu_data = alu; i_ld_data = ld;
    i_instr = {20'h00000, rd, 7'b0010011};
    pend_vld  = vld;
    pend_we   = vld && wren && (rd != 5'd0);
    pend_rd   = pend_we ? rd : 5'd0;
    pend_data = model_wb(sel, pc, alu, ld);
    r.vld = vld; r.pc = pc; r.rd = pend_rd; r.data = pend_data;
    sb.push_back(r);
  endtask

  // One clock edge; model state follows the edge, then the matching record is popped.
  task automatic advance(output ret_t e, output logic got);
    @(posedge i_clk);
    #1;
    if (pend_we) mregs[pend_rd] = pend_data;
    if (pend_vld) minstret = minstret + 64'd1;
    pend_we = 1'b0; pend_vld = 1'b0;
    i_insn_vld = 1'b0; i_rd_wren = 1'b0;
    got = (sb.size() != 0);
    if (got) e = sb.pop_front();
    else begin e.vld = 1'b0; e.pc = '0; e.rd = '0; e.data = '0; end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_total++; if (o_instret !== 64'd0) $display("FAIL reset_instret got %h exp 0", o_instret); else n_pass++;
    n_total++; if (o_retire_vld !== 1'b0) $display("FAIL reset_retire_vld got %b exp 0", o_retire_vld); else n_pass++;
    n_total++;
    if ({o_retire_pc, o_retire_rd, o_retire_data} !== 69'd0)
      $display("FAIL reset_retire_rec got %h/%h/%h exp 0", o_retire_pc, o_retire_rd, o_retire_data);
    else n_pass++;
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    for (int a = 0; a < 32; a++) begin
      i_rs1_addr = 5'(a); i_rs2_addr = 5'(31 - a);
      #1;
      n_total++;
      if ({o_rs1_data, o_rs2_data} !== 64'd0)
        $display("FAIL reset_read x%0d got %h/%h exp 0", a, o_rs1_data, o_rs2_data);
      else n_pass++;
    end
  endtask

  task automatic test_alu_commit();
    ret_t e; logic got;
    drive(1'b1, 1'b1, 5'd5, 2'b01, 32'h0000_1000, 32'hDEADBEEF, 32'h0);
    #1;
    n_total++;
    if ({o_wb_we, o_wb_rd, o_wb_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
      $display("FAIL alu_wb got %b/%0d/%h exp 1/5/deadbeef", o_wb_we, o_wb_rd, o_wb_data);
    else n_pass++;
    advance(e, got);
    n_total++;
    if (!got || {o_retire_vld, o_retire_pc, o_retire_rd, o_retire_data} !== {e.vld, e.pc, e.rd, e.data})
      $display("FAIL alu_retire got %b/%h/%0d/%h exp %b/%h/%0d/%h", o_retire_vld, o_retire_pc,
               o_retire_rd, o_retire_data, e.vld, e.pc, e.rd, e.data);
    else n_pass++;
    i_rs1_addr = 5'd5; i_rs2_addr = 5'd5; #1;
    n_total++; if (o_rs1_data !== 32'hDEADBEEF) $display("FAIL alu_read got %h exp deadbeef", o_rs1_data); else n_pass++;
    n_total++; if (o_instret !== minstret) $display("FAIL alu_instret got %0d exp %0d", o_instret, minstret); else n_pass++;
  endtask

  task automatic test_x0_write();
    ret_t e; logic got;
    drive(1'b1, 1'b1, 5'd0, 2'b01, 32'h0000_1004, 32'h0000_1234, 32'h0);
    #1;
    n_total++;
    if ({o_wb_we, o_wb_rd} !== {1'b0, 5'd0})
      $display("FAIL x0_wb got %b/%0d exp 0/0", o_wb_we, o_wb_rd);
    else n_pass++;
    advance(e, got);
    n_total++;
    if (!got || {o_retire_vld, o_retire_pc, o_retire_rd, o_retire_data} !== {e.vld, e.pc, e.rd, e.data})
      $display("FAIL x0_retire got %b/%h/%0d/%h exp %b/%h/%0d/%h", o_retire_vld, o_retire_pc,
               o_retire_rd, o_retire_data, e.vld, e.pc, e.rd, e.data);
    else n_pass++;
    i_rs1_addr = 5'd0; #1;
    n_total++; if (o_rs1_data !== 32'h0) $display("FAIL x0_read got %h exp 0", o_rs1_data); else n_pass++;
    n_total++; if (o_instret !== 64'd2) $display("FAIL x0_instret got %0d exp 2", o_instret); else n_pass++;
  endtask

  task automatic test_bubble();
    ret_t e; logic got;
    drive(1'b0, 1'b1, 5'd7, 2'b01, 32'h0000_1008, 32'h7777_7777, 32'h0);
    #1;
    n_total++; if (o_wb_we !== 1'b0) $display("FAIL bubble_we got %b exp 0", o_wb_we); else n_pass++;
    advance(e, got);
    n_total++;
    if (!got || {o_retire_vld, o_retire_rd} !== {e.vld, e.rd})
      $display("FAIL bubble_retire got %b/%0d exp %b/%0d", o_retire_vld, o_retire_rd, e.vld, e.rd);
    else n_pass++;
    i_rs1_addr = 5'd7; #1;
    n_total++; if (o_rs1_data !== 32'h0) $display("FAIL bubble_x7 got %h exp 0", o_rs1_data); else n_pass++;
    n_total++; if (o_instret !== 64'd2) $display("FAIL bubble_instret got %0d exp 2", o_instret); else n_pass++;
  endtask

  task automatic test_same_cycle();
    ret_t e; logic got;
    logic [31:0] exp_now;
    drive(1'b1, 1'b1, 5'd3, 2'b01, 32'h0000_100C, 32'h0000_0011, 32'h0);
    advance(e, got);
    i_rs1_addr = 5'd3; i_rs2_addr = 5'd3;
    drive(1'b1, 1'b1, 5'd3, 2'b10, 32'h0000_1010, 32'h0, 32'h0000_0055);
    #1;
`ifdef WB_BYPASS_EN
    exp_now = 32'h55;
`else
    exp_now = 32'h11;
`endif
    n_total++;
    if (o_rs1_data !== exp_now || o_rs2_data !== exp_now)
      $display("FAIL same_cycle_read got %h/%h exp %h", o_rs1_data, o_rs2_data, exp_now);
    else n_pass++;
    advance(e, got);
    n_total++;
    if (!got || {o_retire_vld, o_retire_rd, o_retire_data} !== {e.vld, e.rd, e.data})
      $display("FAIL same_cycle_retire got %b/%0d/%h exp %b/%0d/%h", o_retire_vld, o_retire_rd,
               o_retire_data, e.vld, e.rd, e.data);
    else n_pass++;
    n_total++;
    if (o_rs1_data !== 32'h55 || o_rs2_data !== 32'h55)
      $display("FAIL same_cycle_next got %h/%h exp 55", o_rs1_data, o_rs2_data);
    else n_pass++;
  endtask

  task automatic test_jal_wrap();
    ret_t e; logic got;
    drive(1'b1, 1'b1, 5'd1, 2'b01, 32'h0000_1014, 32'hA5A5_A5A5, 32'h0);
    advance(e, got);
    drive(1'b1, 1'b1, 5'd1, 2'b00, 32'hFFFF_FFFC, 32'h1111_1111, 32'h2222_2222);
    #1;
    n_total++; if (o_wb_data !== 32'h0) $display("FAIL jal_wb_data got %h exp 0", o_wb_data); else n_pass++;
    advance(e, got);
    i_rs1_addr = 5'd1; #1;
    n_total++; if (o_rs1_data !== 32'h0) $display("FAIL jal_x1 got %h exp 0", o_rs1_data); else n_pass++;
    n_total++;
    if (!got || {o_retire_pc, o_retire_rd, o_retire_data} !== {e.pc, e.rd, e.data})
      $display("FAIL jal_retire got %h/%0d/%h exp %h/%0d/%h", o_retire_pc, o_retire_rd,
               o_retire_data, e.pc, e.rd, e.data);
    else n_pass++;
  endtask

  task automatic test_instret_wrap();
    ret_t e; logic got;
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    minstret = '1;
    drive(1'b1, 1'b0, 5'd9, 2'b01, 32'h0000_2000, 32'h0, 32'h0);
    advance(e, got);
    n_total++; if (o_instret !== 64'd0) $display("FAIL instret_wrap got %h exp 0", o_instret); else n_pass++;
  endtask

  task automatic test_mid_reset();
    ret_t e; logic got;
    drive(1'b1, 1'b1, 5'd9, 2'b01, 32'h0000_3000, 32'h9999_9999, 32'h0);
    #1;
    i_rst_n = 1'b0;
    #1;
    i_rs1_addr = 5'd5; i_rs2_addr = 5'd3; #1;
    n_total++;
    if ({o_rs1_data, o_rs2_data} !== 64'd0)
      $display("FAIL midrst_clear got %h/%h exp 0", o_rs1_data, o_rs2_data);
    else n_pass++;
    n_total++;
    if ({o_retire_vld, o_instret} !== 65'd0)
      $display("FAIL midrst_state got %b/%h exp 0", o_retire_vld, o_instret);
    else n_pass++;
    advance(e, got);
    model_clear();
    i_rs1_addr = 5'd9; #1;
    n_total++; if (o_rs1_data !== 32'h0) $display("FAIL midrst_x9 got %h exp 0", o_rs1_data); else n_pass++;
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_back_to_back();
    ret_t e; logic got;
    for (int k = 0; k < 40; k++) begin
      i_rs1_addr = 5'($urandom_range(0, 31));
      i_rs2_addr = 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      #1;
      n_total++;
      if ({o_wb_we, o_wb_rd, o_wb_data} !== {pend_we, pend_rd, pend_data})
        $display("FAIL b2b_wb[%0d] got %b/%0d/%h exp %b/%0d/%h", k, o_wb_we, o_wb_rd, o_wb_data,
                 pend_we, pend_rd, pend_data);
      else n_pass++;
      n_total++;
      if (o_rs1_data !== model_rd(i_rs1_addr) || o_rs2_data !== model_rd(i_rs2_addr))
        $display("FAIL b2b_read[%0d] got %h/%h exp %h/%h", k, o_rs1_data, o_rs2_data,
                 model_rd(i_rs1_addr), model_rd(i_rs2_addr));
      else n_pass++;
      advance(e, got);
      n_total++;
      if (!got || {o_retire_vld, o_retire_pc, o_retire_rd, o_retire_data, o_instret} !==
                  {e.vld, e.pc, e.rd, e.data, minstret})
        $display("FAIL b2b_retire[%0d] got %b/%h/%0d/%h/%0d exp %b/%h/%0d/%h/%0d", k, o_retire_vld,
                 o_retire_pc, o_retire_rd, o_retire_data, o_instret, e.vld, e.pc, e.rd, e.data, minstret);
      else n_pass++;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alu_commit();
    test_x0_write();
    test_bubble();
    test_same_cycle();
    test_jal_wrap();
    test_instret_wrap();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
